// File: rtl/kmi_pkg.sv
// KMI receive shared definitions: frame constants, FSM state encoding and the
// odd-parity helper used by kmi_rx.
package kmi_pkg;

  localparam int KMI_DATA_BITS  = 8;
  localparam int KMI_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } kmi_state_t;

  // Odd parity holds when data bits plus parity bit contain an odd number of ones.
  function automatic logic odd_parity_ok(input logic [KMI_DATA_BITS-1:0] data,
                                         input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/kmi_sync_edge.sv
// Two-flop synchroniser and falling-edge strobe for the KMI clock line.
// Optional glitch filter enabled by the KMI_RX_FILTER_EN macro: the filtered
// level only changes after FILTER_LEN consecutive equal synchronised samples.
module kmi_sync_edge #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_in,
  output logic fall_strobe
);

  if (FILTER_LEN < 2) begin : g_filter_len_chk
    $error("kmi_sync_edge: FILTER_LEN must be at least 2");
  end

  logic [1:0] sync_q;
  logic       line_s;

  // Synchroniser resets high so an idle bus produces no spurious edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], line_in};
  end

  assign line_s = sync_q[1];

`ifdef KMI_RX_FILTER_EN
  logic [FILTER_LEN-2:0] hist_q;
  logic                  filt_q;
  logic                  all_low;
  logic                  all_high;

  // The current synchronised sample plus FILTER_LEN-1 older ones form the window.
  assign all_low  = ~line_s & ~(|hist_q);
  assign all_high =  line_s &  (&hist_q);

  // Sample history shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_q <= '1;
    end else begin
      for (int i = FILTER_LEN - 2; i > 0; i--) hist_q[i] <= hist_q[i-1];
      hist_q[0] <= line_s;
    end
  end

  // Filtered level follows the window only when it is unanimous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        filt_q <= 1'b1;
    else if (all_low)  filt_q <= 1'b0;
    else if (all_high) filt_q <= 1'b1;
  end

  // Strobe in the first cycle the window becomes all-low while the level is high.
  always_comb begin
    fall_strobe = filt_q & all_low;
  end
`else
  logic prev_q;

  // Previous synchronised level for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= line_s;
  end

  // Falling edge: high last cycle, low now.
  always_comb begin
    fall_strobe = prev_q & ~line_s;
  end
`endif

endmodule

// File: rtl/kmi_rx.sv
// KMI (PS/2-style) receive stage: synchronises kmiclk/kmidata, deserialises
// 11-bit frames and holds each byte with its parity status until rx_done.
// Optional macro KMI_RX_FILTER_EN adds a glitch filter on the kmiclk line.
//
// state     | meaning
// ----------+---------------------------------------------
// ST_IDLE   | waiting for a start bit (0) on a clock edge
// ST_DATA   | shifting in 8 data bits, LSB first
// ST_PARITY | capturing the parity bit
// ST_STOP   | checking the stop bit, completing the frame
module kmi_rx
  import kmi_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int FILTER_LEN     = 4
) (
  input  logic       pclk,
  input  logic       npreset,
  input  logic       kmiclk_in,
  input  logic       kmidata_in,
  input  logic       rx_done,
  output logic [7:0] rx_data,
  output logic       receive,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int CW = $clog2(KMI_DATA_BITS);

  if (KMI_FRAME_BITS != KMI_DATA_BITS + 3) begin : g_frame_chk
    $error("kmi_rx: frame must be start + data + parity + stop");
  end

  kmi_state_t state_q, state_d;

  logic                     edge_stb;
  logic [1:0]               dsync_q;
  logic                     bit_in;
  logic [KMI_DATA_BITS-1:0] shift_q;
  logic [CW-1:0]            bit_cnt_q;
  logic                     par_q;
  logic [TW-1:0]            tout_q;

  logic                     shift_en;
  logic                     par_en;
  logic                     tout_hit;
  logic                     frame_done;
  logic                     stop_bad;

  logic [7:0]               rx_data_q;
  logic                     receive_q;
  logic                     parity_err_q;
  logic                     frame_err_q;
  logic                     overrun_q;

  kmi_sync_edge #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_sync (
    .clk         (pclk),
    .rst_n       (npreset),
    .line_in     (kmiclk_in),
    .fall_strobe (edge_stb)
  );

  // Plain two-flop synchroniser for the data line, idle high.
  always_ff @(posedge pclk or negedge npreset) begin
    if (!npreset) dsync_q <= 2'b11;
    else          dsync_q <= {dsync_q[0], kmidata_in};
  end

  assign bit_in = dsync_q[1];

  // State register.
  always_ff @(posedge pclk or negedge npreset) begin
    if (!npreset) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a timeout aborts any in-progress frame.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (edge_stb && !bit_in) state_d = ST_DATA;
      ST_DATA:   if (edge_stb && bit_cnt_q == CW'(KMI_DATA_BITS - 1)) state_d = ST_PARITY;
      ST_PARITY: if (edge_stb) state_d = ST_STOP;
      ST_STOP:   if (edge_stb) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (tout_hit) state_d = ST_IDLE;
  end

  // Output decode of the FSM.
  always_comb begin
    tout_hit   = (state_q != ST_IDLE) && (tout_q == TW'(TIMEOUT_CYCLES - 1));
    shift_en   = (state_q == ST_DATA)   && edge_stb && !tout_hit;
    par_en     = (state_q == ST_PARITY) && edge_stb && !tout_hit;
    frame_done = (state_q == ST_STOP)   && edge_stb && !tout_hit &&  bit_in;
    stop_bad   = (state_q == ST_STOP)   && edge_stb && !tout_hit && !bit_in;
    rx_busy    = (state_q != ST_IDLE);
  end

  // Shift register, bit counter and parity capture.
  always_ff @(posedge pclk or negedge npreset) begin
    if (!npreset) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
      par_q     <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) bit_cnt_q <= '0;
      if (shift_en) begin
        shift_q[bit_cnt_q] <= bit_in;
        bit_cnt_q          <= bit_cnt_q + 1'b1;
      end
      if (par_en) par_q <= bit_in;
    end
  end

  // Timeout counter: idle or any clock edge restarts it.
  always_ff @(posedge pclk or negedge npreset) begin
    if (!npreset)                           tout_q <= '0;
    else if (state_q == ST_IDLE || edge_stb) tout_q <= '0;
    else                                    tout_q <= tout_q + 1'b1;
  end

  // Held byte and handshake; error pulses never touch the held byte.
  always_ff @(posedge pclk or negedge npreset) begin
    if (!npreset) begin
      rx_data_q    <= '0;
      receive_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      frame_err_q <= stop_bad | tout_hit;
      overrun_q   <= frame_done & receive_q & ~rx_done;
      if (frame_done && (!receive_q || rx_done)) begin
        rx_data_q    <= shift_q;
        parity_err_q <= ~odd_parity_ok(shift_q, par_q);
        receive_q    <= 1'b1;
      end else if (rx_done && receive_q && !frame_done) begin
        receive_q    <= 1'b0;
        parity_err_q <= 1'b0;
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign receive    = receive_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_kmi_rx.sv
// Directed bench for kmi_rx: frames driven on the pins with hand-computed
// expectations for data, parity, stop errors, overrun, timeout and reset.
module tb_kmi_rx;

  localparam int TIMEOUT = 4096;
`ifdef KMI_RX_FILTER_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 3;
`endif

  logic       pclk = 1'b0;
  logic       npreset;
  logic       kmiclk_in;
  logic       kmidata_in;
  logic       rx_done;
  logic [7:0] rx_data;
  logic       receive;
  logic       parity_err;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  int total = 0;
  int bad   = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int fe0, ov0;

  kmi_rx #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .FILTER_LEN     (4)
  ) dut (
    .pclk       (pclk),
    .npreset    (npreset),
    .kmiclk_in  (kmiclk_in),
    .kmidata_in (kmidata_in),
    .rx_done    (rx_done),
    .rx_data    (rx_data),
    .receive    (receive),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .rx_busy    (rx_busy)
  );

  always #5 pclk = ~pclk;

  // Count high cycles of the pulse outputs; a one-cycle pulse counts once.
  always @(negedge pclk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic fall_bit(input logic b);
    @(negedge pclk);
    kmidata_in = b;
    repeat (20) @(negedge pclk);
    kmiclk_in = 1'b0;
  endtask

  task automatic rise_bit();
    repeat (20) @(negedge pclk);
    kmiclk_in = 1'b1;
  endtask

  task automatic drive_bit(input logic b);
    fall_bit(b);
    rise_bit();
  endtask

  task automatic send_head(input logic [7:0] d, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(par);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    send_head(d, par);
    drive_bit(stop);
    repeat (10) @(negedge pclk);
    kmidata_in = 1'b1;
  endtask

  task automatic ack();
    @(negedge pclk);
    rx_done = 1'b1;
    @(negedge pclk);
    rx_done = 1'b0;
  endtask

  initial begin
    npreset    = 1'b0;
    kmiclk_in  = 1'b1;
    kmidata_in = 1'b1;
    rx_done    = 1'b0;
    repeat (5) @(negedge pclk);
    chk_val("rst_rx_data", rx_data, 8'h00);
    chk_val("rst_receive", receive, 0);
    chk_val("rst_parity_err", parity_err, 0);
    chk_val("rst_frame_err", frame_err, 0);
    chk_val("rst_overrun", overrun, 0);
    chk_val("rst_busy", rx_busy, 0);
    npreset = 1'b1;
    repeat (5) @(negedge pclk);

    // 0x6C has four ones, so parity 1 is correct; check completion latency.
    send_head(8'h6C, 1'b1);
    fall_bit(1'b1);
    repeat (LAT - 1) @(posedge pclk);
    #1 chk_val("lat_before", receive, 0);
    @(posedge pclk);
    #1 chk_val("lat_at", receive, 1);
    rise_bit();
    chk_val("t1_data", rx_data, 8'h6C);
    chk_val("t1_perr", parity_err, 0);
    ack();
    chk_val("t1_ack_recv", receive, 0);
    chk_val("t1_ack_data", rx_data, 8'h6C);

    // rx_done while nothing is held has no effect.
    ack();
    chk_val("idle_ack_recv", receive, 0);

    // 0x07 has three ones; parity 1 is wrong.
    send_frame(8'h07, 1'b1, 1'b1);
    chk_val("t2_recv", receive, 1);
    chk_val("t2_data", rx_data, 8'h07);
    chk_val("t2_perr", parity_err, 1);
    ack();
    chk_val("t2_ack_perr", parity_err, 0);

    // Stop bit 0: one frame_err pulse, nothing held.
    fe0 = fe_cnt;
    send_frame(8'hDE, 1'b1, 1'b0);
    chk_val("t3_fe_pulses", fe_cnt - fe0, 1);
    chk_val("t3_recv", receive, 0);
    chk_val("t3_busy", rx_busy, 0);

    // Overrun: 0x6C held, 0x05 arrives unacknowledged.
    send_frame(8'h6C, 1'b1, 1'b1);
    ov0 = ov_cnt;
    send_frame(8'h05, 1'b1, 1'b1);
    chk_val("t4_ov_pulses", ov_cnt - ov0, 1);
    chk_val("t4_ov_data", rx_data, 8'h6C);
    chk_val("t4_ov_recv", receive, 1);
    chk_val("t4_ov_perr", parity_err, 0);

    // rx_done coincident with completion: new byte replaces the held one.
    ov0 = ov_cnt;
    send_head(8'h05, 1'b1);
    fall_bit(1'b1);
    repeat (LAT - 1) @(negedge pclk);
    rx_done = 1'b1;
    @(negedge pclk);
    rx_done = 1'b0;
    rise_bit();
    chk_val("t4_co_data", rx_data, 8'h05);
    chk_val("t4_co_recv", receive, 1);
    chk_val("t4_co_ov", ov_cnt - ov0, 0);
    ack();

    // Timeout after the start bit and four data bits of 0xDE.
    fe0 = fe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i == 0 ? 1'b0 : 1'b1);
    repeat (4000) @(negedge pclk);
    chk_val("t5_busy_early", rx_busy, 1);
    chk_val("t5_fe_early", fe_cnt - fe0, 0);
    repeat (200) @(negedge pclk);
    chk_val("t5_fe_pulses", fe_cnt - fe0, 1);
    chk_val("t5_busy_after", rx_busy, 0);
    kmidata_in = 1'b1;
    send_frame(8'hDE, 1'b1, 1'b1);
    chk_val("t5_data", rx_data, 8'hDE);
    chk_val("t5_perr", parity_err, 0);
    chk_val("t5_recv", receive, 1);

`ifdef KMI_RX_FILTER_EN
    // Short low glitch with data low must not start a frame.
    @(negedge pclk);
    kmidata_in = 1'b0;
    @(negedge pclk);
    kmiclk_in = 1'b0;
    repeat (2) @(negedge pclk);
    kmiclk_in = 1'b1;
    repeat (20) @(negedge pclk);
    chk_val("glitch_busy", rx_busy, 0);
    kmidata_in = 1'b1;
`endif

    // Reset mid-frame while 0xDE is still held.
    drive_bit(1'b0);
    for (int i = 0; i < 5; i++) drive_bit(1'b0);
    chk_val("t6_busy_pre", rx_busy, 1);
    @(negedge pclk);
    #2 npreset = 1'b0;
    #1;
    chk_val("t6_rst_data", rx_data, 8'h00);
    chk_val("t6_rst_recv", receive, 0);
    chk_val("t6_rst_busy", rx_busy, 0);
    kmidata_in = 1'b1;
    repeat (3) @(negedge pclk);
    npreset = 1'b1;
    repeat (5) @(negedge pclk);
    send_frame(8'h6C, 1'b1, 1'b1);
    chk_val("t6_data", rx_data, 8'h6C);
    chk_val("t6_recv", receive, 1);
    chk_val("t6_perr", parity_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
